// File: rtl/horizontal_tf_table_loader.sv
// Programmable twiddle-factor table: streamed in over valid/ready, then replayed
// to the row-1 radix-16 butterfly at one index per 16 stage-0 enabled cycles.
module horizontal_tf_table_loader #(
  parameter int P_WIDTH   = 64,
  parameter int SC_WIDTH  = 3,
  parameter int DEPTH     = 64,
  parameter int START_IDX = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [P_WIDTH-1:0]  wr_data,
  output logic                load_busy,
  output logic                load_done,
  input  logic [SC_WIDTH-1:0] stage_counter,
  input  logic                CEN,
  output logic [P_WIDTH-1:0]  Q,
  output logic [5:0]          tf_idx
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t             state, state_nxt;
  logic [5:0]         wr_ptr;
  logic [3:0]         cnt;
  logic [P_WIDTH-1:0] tbl [DEPTH];
  logic               beat;
  logic               rd_en;
  logic               stage0;

  assign wr_ready  = (state == LOAD);
  assign load_busy = (state == LOAD);
  assign load_done = (state == DONE);
  // A beat coinciding with a restart pulse is dropped so the new load starts clean.
  assign beat      = wr_valid && wr_ready && !load_start;
  assign rd_en     = load_done && !CEN;
  assign stage0    = (stage_counter == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load_start) state_nxt = LOAD;
      LOAD: begin
        if (load_start)                  state_nxt = LOAD;
        else if (beat && wr_ptr == 6'd63) state_nxt = DONE;
      end
      DONE: if (load_start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          wr_ptr <= '0;
    else if (load_start) wr_ptr <= '0;
    else if (beat)       wr_ptr <= wr_ptr + 6'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (beat) begin
      tbl[wr_ptr] <= wr_data;
    end
  end

  // Replay cadence: 16 stage-0 reads per index, index wraps 63 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      tf_idx <= 6'(START_IDX);
    end else if (load_start) begin
      cnt    <= '0;
      tf_idx <= 6'(START_IDX);
    end else if (rd_en && stage0) begin
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15) tf_idx <= tf_idx + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     Q <= '0;
    else if (rd_en) Q <= tbl[tf_idx];
  end

endmodule

// File: doc/horizontal_tf_table_loader.md
Name: horizontal_tf_table_loader

Overview:
- Programmable replacement for the fixed horizontal twiddle-factor ROM that feeds the row-1 radix-16 butterfly.
- Write side: a host or DMA streams 64 twiddle factors (P_WIDTH bits each) into a 64-entry register table over a valid/ready handshake.
- Read side: once the load completes, the table is replayed to the butterfly on Q using the same cadence as the fixed generator: one table index per 16 stage-0 enabled cycles, Q registered.

Parameters:
- P_WIDTH, 64, twiddle word width
- SC_WIDTH, 3, stage_counter width
- DEPTH, 64, table entries; fixed power of two, index width 6
- START_IDX, 1, first index replayed after load or reset (entry 0 is the unused unity factor)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_start  input  1  one-cycle pulse; begins or restarts a table load
- wr_valid  input  1  wr_data is valid this cycle
- wr_ready  output  1  table accepts a word this cycle
- wr_data  input  P_WIDTH  twiddle word; written at the current write pointer
- load_busy  output  1  high while in LOAD
- load_done  output  1  high while in DONE; table valid
- stage_counter  input  SC_WIDTH  butterfly stage; the index advances only in stage 0
- CEN  input  1  active-low read enable from the butterfly controller
- Q  output  P_WIDTH  registered twiddle factor to the butterfly
- tf_idx  output  6  table index currently being replayed (debug/verification)

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE, wr_ptr=0, cnt=0, tf_idx=START_IDX, Q=0, all table entries=0, wr_ready=0, load_busy=0, load_done=0.
- FSM states:
  - IDLE: load_start -> LOAD.
  - LOAD: a beat is accepted when wr_valid && wr_ready. Each beat writes table[wr_ptr] <= wr_data and increments wr_ptr. The beat with wr_ptr==63 -> DONE.
  - DONE: holds until the next load_start -> LOAD.
- On entering LOAD from any state: wr_ptr=0, cnt=0, tf_idx=START_IDX, load_done=0 on the next cycle. Q holds its value. Table entries not yet overwritten keep their old contents.
- load_start while in LOAD restarts the load: wr_ptr=0. A beat offered in the same cycle is discarded.
- wr_ready = (state==LOAD) and is combinational from state. wr_valid outside LOAD is ignored.
- load_busy = (state==LOAD). load_done = (state==DONE).
- Read enable: rd_en = (state==DONE) && !CEN.
- cnt (4 bits):
  - Increments when rd_en && stage_counter==0; wraps 15->0.
  - Holds otherwise, including when CEN=1 or in any other stage.
- tf_idx advances only on the cycle cnt wraps (rd_en && stage_counter==0 && cnt==15). It wraps 63->0 and is otherwise held.
- Q:
  - When rd_en: Q <= table[tf_idx] (tf_idx value before its update), giving 1-cycle latency.
  - When !rd_en: Q holds.
- Read and write never overlap, because reads require DONE. A same-cycle load_start and rd_en still performs that cycle's read; cnt and tf_idx are then reinitialised.
- Reset mid-load: returns to IDLE with an all-zero table. A full reload is required.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> immediately Q=0, tf_idx=1, wr_ready=0, load_done=0. After release, with no load_start, CEN=0 leaves Q=0.
- Load with gaps: pulse load_start, then stream words k*0x0101010101010101 + k (k=0..63) with wr_valid deasserted every third cycle. Require load_busy high, then exactly 64 accepted beats, then load_done=1 one cycle after beat 63, then wr_ready=0.
- Replay cadence: CEN=0, stage_counter=0 for 40 cycles. Require:
  - Q = word1 from cycle 1 through cycle 16.
  - Q = word2 starting one cycle after cnt wraps.
  - tf_idx = 1,1,…,2 with exactly 16 reads per index.
- Stall: toggle CEN=1 for 5 cycles and stage_counter=2 for 7 cycles mid-group. Require cnt, tf_idx and Q frozen, then resuming at the same count.
- Wrap: run 63*16 enabled stage-0 cycles -> tf_idx goes 63 -> 0, and Q = word0 is output, then word1.
- Restart: after 20 beats, pulse load_start with wr_valid=1 -> that beat is dropped and wr_ptr=0; 64 further beats are required before load_done. Assert rst_n=0 at beat 30 of a second load -> IDLE, and a table readback after reload shows no stale data.
